// File: rtl/rc2014_bus_master.sv
// rtl/rc2014_bus_master.sv - Z80-style RC2014 bus initiator: runs one memory or I/O cycle per command
module rc2014_bus_master #(
    parameter int unsigned T_CLKS   = 1,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic        cmd_write,
    input  logic        cmd_io,
    input  logic        cmd_m1,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] A_OUT,
    output logic [7:0]  D_OUT,
    input  logic [7:0]  D_IN,
    output logic        D_OE,
    output logic        MRQ,
    output logic        IORQ,
    output logic        RD,
    output logic        WR,
    output logic        M1,
    input  logic        WAIT
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_TH} state_t;

    localparam logic [3:0] LP_TICK_LAST = 4'(T_CLKS - 1);
    localparam logic [7:0] LP_WAIT_MAX  = 8'(WAIT_MAX);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_tick, w_tick_nxt;
    logic [7:0]  r_wcnt, w_wcnt_nxt;
    logic        r_abort, w_abort_nxt;
    logic        r_write, w_write_nxt;
    logic        r_io, w_io_nxt;
    logic        r_m1, w_m1_nxt;
    logic        r_cmd_ready, w_cmd_ready_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic        r_rsp_err, w_rsp_err_nxt;
    logic [7:0]  r_rdata, w_rdata_nxt;
    logic [15:0] r_a_out, w_a_out_nxt;
    logic [7:0]  r_d_out, w_d_out_nxt;
    logic        r_d_oe, w_d_oe_nxt;
    logic        r_mrq_n, w_mrq_n_nxt;
    logic        r_iorq_n, w_iorq_n_nxt;
    logic        r_rd_n, w_rd_n_nxt;
    logic        r_wr_n, w_wr_n_nxt;
    logic        r_m1_n, w_m1_n_nxt;
    logic        w_last;
    logic        w_active;

    assign w_last = (r_tick == LP_TICK_LAST);

    // Register state, latched command and every bus/response output
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_tick      <= 4'd0;
            r_wcnt      <= 8'd0;
            r_abort     <= 1'b0;
            r_write     <= 1'b0;
            r_io        <= 1'b0;
            r_m1        <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= 8'd0;
            r_a_out     <= 16'd0;
            r_d_out     <= 8'd0;
            r_d_oe      <= 1'b0;
            r_mrq_n     <= 1'b1;
            r_iorq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_m1_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_abort     <= w_abort_nxt;
            r_write     <= w_write_nxt;
            r_io        <= w_io_nxt;
            r_m1        <= w_m1_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rdata     <= w_rdata_nxt;
            r_a_out     <= w_a_out_nxt;
            r_d_out     <= w_d_out_nxt;
            r_d_oe      <= w_d_oe_nxt;
            r_mrq_n     <= w_mrq_n_nxt;
            r_iorq_n    <= w_iorq_n_nxt;
            r_rd_n      <= w_rd_n_nxt;
            r_wr_n      <= w_wr_n_nxt;
            r_m1_n      <= w_m1_n_nxt;
        end
    end

    // Next-state logic; strobes are derived from the state being entered so they change on the edge itself
    always_comb begin
        w_state_nxt     = r_state;
        w_tick_nxt      = w_last ? 4'd0 : r_tick + 4'd1;
        w_wcnt_nxt      = r_wcnt;
        w_abort_nxt     = r_abort;
        w_write_nxt     = r_write;
        w_io_nxt        = r_io;
        w_m1_nxt        = r_m1;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_a_out_nxt     = r_a_out;
        w_d_out_nxt     = r_d_out;
        w_d_oe_nxt      = r_d_oe;

        case (r_state)
            S_IDLE: begin
                w_tick_nxt = 4'd0;
                if (cmd_valid) begin
                    w_write_nxt = cmd_write;
                    w_io_nxt    = cmd_io;
                    w_m1_nxt    = cmd_m1;
                    w_abort_nxt = 1'b0;
                    w_a_out_nxt = cmd_addr;
                    if (cmd_write) begin
                        w_d_out_nxt = cmd_wdata;
                        w_d_oe_nxt  = 1'b1;
                    end
                    w_state_nxt = S_T1;
                end
            end
            S_T1: begin
                if (w_last) w_state_nxt = S_T2;
            end
            S_T2: begin
                // I/O cycles always insert one wait state, which counts toward the limit
                if (w_last) begin
                    if (r_io || !WAIT) begin
                        w_state_nxt = S_TW;
                        w_wcnt_nxt  = 8'd1;
                    end else begin
                        w_state_nxt = S_T3;
                    end
                end
            end
            S_TW: begin
                if (w_last) begin
                    if (!WAIT) begin
                        if (r_wcnt < LP_WAIT_MAX) begin
                            w_wcnt_nxt = r_wcnt + 8'd1;
                        end else begin
                            w_abort_nxt = 1'b1;
                            w_state_nxt = S_T3;
                        end
                    end else begin
                        w_state_nxt = S_T3;
                    end
                end
            end
            S_T3: begin
                if (w_last) begin
                    if (!r_write && !r_abort) w_rdata_nxt = D_IN;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = r_abort;
                    w_state_nxt     = r_write ? S_TH : S_IDLE;
                end
            end
            S_TH: begin
                if (w_last) begin
                    w_d_oe_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_d_oe_nxt  = 1'b0;
            end
        endcase

        w_active        = (w_state_nxt == S_T2) || (w_state_nxt == S_TW) || (w_state_nxt == S_T3);
        w_mrq_n_nxt     = !(w_active && !r_io);
        w_iorq_n_nxt    = !(w_active && r_io);
        w_rd_n_nxt      = !(w_active && !r_write);
        w_wr_n_nxt      = !(w_active && r_write);
        w_m1_n_nxt      = !(w_active && !r_io && !r_write && r_m1);
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;
    assign A_OUT     = r_a_out;
    assign D_OUT     = r_d_out;
    assign D_OE      = r_d_oe;
    assign MRQ       = r_mrq_n;
    assign IORQ      = r_iorq_n;
    assign RD        = r_rd_n;
    assign WR        = r_wr_n;
    assign M1        = r_m1_n;

endmodule

// File: tb/tb_rc2014_bus_master.sv
// tb/tb_rc2014_bus_master.sv - directed self-checking bench for rc2014_bus_master
module tb_rc2014_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld_a, vld_b;
    logic [15:0] addr;
    logic [7:0]  wdata, d_in;
    logic        c_write, c_io, c_m1, wait_n;

    logic        rdy_a, rspv_a, err_a, doe_a, mrq_a, iorq_a, rd_a, wr_a, m1_a;
    logic [7:0]  rdata_a, dout_a;
    logic [15:0] aout_a;
    logic        rdy_b, rspv_b, err_b, doe_b, mrq_b, iorq_b, rd_b, wr_b, m1_b;
    logic [7:0]  rdata_b, dout_b;
    logic [15:0] aout_b;

    logic        sel_b;
    logic        m_rdy, m_rspv, m_err, m_doe, m_mrq, m_iorq, m_rd, m_wr, m_m1;
    logic [7:0]  m_rdata, m_dout;
    logic [15:0] m_aout;

    int errors = 0;
    int checks = 0;

    int          s_mrq, s_iorq, s_rd, s_wr, s_m1, s_doe, s_rdy, s_rsp, s_edge;
    logic        s_err;
    logic [7:0]  s_rdata, s_dout_wr;
    logic [15:0] s_aout1;

    always #5 clk = ~clk;

    rc2014_bus_master #(.T_CLKS(1), .WAIT_MAX(4)) u_a (
        .CLK(clk), .RST(rst_n), .cmd_valid(vld_a), .cmd_ready(rdy_a),
        .cmd_addr(addr), .cmd_wdata(wdata), .cmd_write(c_write), .cmd_io(c_io), .cmd_m1(c_m1),
        .rsp_valid(rspv_a), .rsp_rdata(rdata_a), .rsp_err(err_a),
        .A_OUT(aout_a), .D_OUT(dout_a), .D_IN(d_in), .D_OE(doe_a),
        .MRQ(mrq_a), .IORQ(iorq_a), .RD(rd_a), .WR(wr_a), .M1(m1_a), .WAIT(wait_n)
    );

    rc2014_bus_master #(.T_CLKS(3), .WAIT_MAX(255)) u_b (
        .CLK(clk), .RST(rst_n), .cmd_valid(vld_b), .cmd_ready(rdy_b),
        .cmd_addr(addr), .cmd_wdata(wdata), .cmd_write(c_write), .cmd_io(c_io), .cmd_m1(c_m1),
        .rsp_valid(rspv_b), .rsp_rdata(rdata_b), .rsp_err(err_b),
        .A_OUT(aout_b), .D_OUT(dout_b), .D_IN(d_in), .D_OE(doe_b),
        .MRQ(mrq_b), .IORQ(iorq_b), .RD(rd_b), .WR(wr_b), .M1(m1_b), .WAIT(wait_n)
    );

    assign m_rdy   = sel_b ? rdy_b   : rdy_a;
    assign m_rspv  = sel_b ? rspv_b  : rspv_a;
    assign m_err   = sel_b ? err_b   : err_a;
    assign m_doe   = sel_b ? doe_b   : doe_a;
    assign m_mrq   = sel_b ? mrq_b   : mrq_a;
    assign m_iorq  = sel_b ? iorq_b  : iorq_a;
    assign m_rd    = sel_b ? rd_b    : rd_a;
    assign m_wr    = sel_b ? wr_b    : wr_a;
    assign m_m1    = sel_b ? m1_b    : m1_a;
    assign m_rdata = sel_b ? rdata_b : rdata_a;
    assign m_dout  = sel_b ? dout_b  : dout_a;
    assign m_aout  = sel_b ? aout_b  : aout_a;

    // Issue one command on the selected instance and tally per-cycle activity; edge 0 is the accept edge.
    // WAIT is low at edges 1..wu and high otherwise.
    task automatic run_cmd(input logic [15:0] a, input logic [7:0] wd, input logic w, input logic io,
                           input logic m, input int wu, input int n_edges);
        s_mrq = 0; s_iorq = 0; s_rd = 0; s_wr = 0; s_m1 = 0; s_doe = 0; s_rdy = 0; s_rsp = 0;
        s_edge = -1; s_err = 1'b0; s_rdata = 8'hxx; s_dout_wr = 8'hxx; s_aout1 = 16'hxxxx;
        @(negedge clk);
        addr = a; wdata = wd; c_write = w; c_io = io; c_m1 = m; wait_n = 1'b1;
        if (sel_b) vld_b = 1'b1; else vld_a = 1'b1;
        for (int e = 0; e < n_edges; e++) begin
            @(posedge clk); #1;
            vld_a = 1'b0; vld_b = 1'b0;
            wait_n = ((e + 1) <= wu) ? 1'b0 : 1'b1;
            if (!m_mrq)  s_mrq++;
            if (!m_iorq) s_iorq++;
            if (!m_rd)   s_rd++;
            if (!m_m1)   s_m1++;
            if (m_doe)   s_doe++;
            if (!m_rdy)  s_rdy++;
            if (!m_wr) begin s_wr++; s_dout_wr = m_dout; end
            if (e == 1) s_aout1 = m_aout;
            if (m_rspv) begin s_rsp++; s_edge = e; s_err = m_err; s_rdata = m_rdata; end
        end
        wait_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; vld_a = 1'b0; vld_b = 1'b0; sel_b = 1'b0;
        addr = 16'h0; wdata = 8'h0; d_in = 8'h0; c_write = 1'b0; c_io = 1'b0; c_m1 = 1'b0; wait_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mrq_a, iorq_a, rd_a, wr_a, m1_a} !== 5'b11111) begin errors++; $display("FAIL reset_strobes: got %b expected 11111", {mrq_a, iorq_a, rd_a, wr_a, m1_a}); end
        checks++; if ({doe_a, rspv_a, err_a, rdy_a} !== 4'b0001) begin errors++; $display("FAIL reset_ctrl: got %b expected 0001", {doe_a, rspv_a, err_a, rdy_a}); end
        checks++; if ({aout_a, dout_a, rdata_a} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {aout_a, dout_a, rdata_a}); end
        checks++; if ({mrq_b, iorq_b, rd_b, wr_b, m1_b, doe_b, rdy_b} !== 7'b1111101) begin errors++; $display("FAIL reset_b: got %b expected 1111101", {mrq_b, iorq_b, rd_b, wr_b, m1_b, doe_b, rdy_b}); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_mem_read;
        d_in = 8'hA5;
        run_cmd(16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8);
        checks++; if (s_mrq !== 2) begin errors++; $display("FAIL mrd_mrq_low: got %0d expected 2", s_mrq); end
        checks++; if (s_rd !== 2) begin errors++; $display("FAIL mrd_rd_low: got %0d expected 2", s_rd); end
        checks++; if (s_iorq + s_wr + s_m1 !== 0) begin errors++; $display("FAIL mrd_other_strobes: got %0d expected 0", s_iorq + s_wr + s_m1); end
        checks++; if (s_rsp !== 1 || s_edge !== 3) begin errors++; $display("FAIL mrd_rsp: got count %0d edge %0d expected 1 at 3", s_rsp, s_edge); end
        checks++; if (s_rdata !== 8'hA5 || s_err !== 1'b0) begin errors++; $display("FAIL mrd_data: got %h err %b expected a5 err 0", s_rdata, s_err); end
        checks++; if (s_aout1 !== 16'h1234) begin errors++; $display("FAIL mrd_addr: got %h expected 1234", s_aout1); end
        checks++; if (s_rdy !== 3) begin errors++; $display("FAIL mrd_ready_low: got %0d expected 3", s_rdy); end
    endtask

    task automatic test_mem_write;
        d_in = 8'hFF;
        run_cmd(16'h8000, 8'h3C, 1'b1, 1'b0, 1'b0, 0, 8);
        checks++; if (s_doe !== 4) begin errors++; $display("FAIL mwr_doe_high: got %0d expected 4", s_doe); end
        checks++; if (s_wr !== 2 || s_rd !== 0 || s_mrq !== 2) begin errors++; $display("FAIL mwr_strobes: got wr %0d rd %0d mrq %0d expected 2 0 2", s_wr, s_rd, s_mrq); end
        checks++; if (s_dout_wr !== 8'h3C) begin errors++; $display("FAIL mwr_dout: got %h expected 3c", s_dout_wr); end
        checks++; if (s_rdy !== 4) begin errors++; $display("FAIL mwr_ready_low: got %0d expected 4", s_rdy); end
        checks++; if (s_edge !== 3 || s_err !== 1'b0) begin errors++; $display("FAIL mwr_rsp: got edge %0d err %b expected 3 0", s_edge, s_err); end
        checks++; if (s_rdata !== 8'hA5) begin errors++; $display("FAIL mwr_rdata_hold: got %h expected a5", s_rdata); end
    endtask

    task automatic test_io_read;
        d_in = 8'h5A;
        run_cmd(16'h00FE, 8'h00, 1'b0, 1'b1, 1'b1, 5, 12);
        checks++; if (s_iorq !== 6 || s_rd !== 6) begin errors++; $display("FAIL io_strobes: got iorq %0d rd %0d expected 6 6", s_iorq, s_rd); end
        checks++; if (s_mrq !== 0 || s_m1 !== 0) begin errors++; $display("FAIL io_mrq_m1: got mrq %0d m1 %0d expected 0 0", s_mrq, s_m1); end
        checks++; if (s_edge !== 7 || s_rdata !== 8'h5A || s_err !== 1'b0) begin errors++; $display("FAIL io_rsp: got edge %0d data %h err %b expected 7 5a 0", s_edge, s_rdata, s_err); end
        checks++; if (s_rdy !== 7) begin errors++; $display("FAIL io_ready_low: got %0d expected 7", s_rdy); end
    endtask

    task automatic test_wait_timeout;
        d_in = 8'h77;
        run_cmd(16'h4000, 8'h00, 1'b0, 1'b0, 1'b0, 100, 12);
        checks++; if (s_mrq !== 6) begin errors++; $display("FAIL to_mrq_low: got %0d expected 6", s_mrq); end
        checks++; if (s_rsp !== 1 || s_edge !== 7 || s_err !== 1'b1) begin errors++; $display("FAIL to_rsp: got count %0d edge %0d err %b expected 1 7 1", s_rsp, s_edge, s_err); end
        checks++; if (s_rdata !== 8'h5A) begin errors++; $display("FAIL to_rdata_hold: got %h expected 5a", s_rdata); end
    endtask

    task automatic test_tclks3;
        sel_b = 1'b1;
        d_in = 8'hC3;
        run_cmd(16'h0100, 8'h00, 1'b0, 1'b0, 1'b1, 0, 14);
        checks++; if (s_m1 !== 6 || s_mrq !== 6 || s_rd !== 6) begin errors++; $display("FAIL t3_strobes: got m1 %0d mrq %0d rd %0d expected 6 6 6", s_m1, s_mrq, s_rd); end
        checks++; if (s_rsp !== 1 || s_edge !== 9) begin errors++; $display("FAIL t3_rsp: got count %0d edge %0d expected 1 9", s_rsp, s_edge); end
        checks++; if (s_rdata !== 8'hC3 || s_rdy !== 9) begin errors++; $display("FAIL t3_data: got %h ready_low %0d expected c3 9", s_rdata, s_rdy); end
        sel_b = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0]  mask;
        logic [7:0]  rd1, rd2;
        logic [15:0] a2, a4;
        logic        rdy3, rdy4;
        mask = '0; rd1 = 8'h00; rd2 = 8'h00; a2 = 16'h0; a4 = 16'h0; rdy3 = 1'b0; rdy4 = 1'b1;
        @(negedge clk);
        d_in = 8'h11; addr = 16'h1000; c_write = 1'b0; c_io = 1'b0; c_m1 = 1'b0; wait_n = 1'b1; vld_a = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            mask[e] = rspv_a;
            if (e == 2) a2 = aout_a;
            if (e == 3) begin rd1 = rdata_a; rdy3 = rdy_a; end
            if (e == 4) begin a4 = aout_a; rdy4 = rdy_a; end
            if (e == 7) rd2 = rdata_a;
            if (e == 0) addr = 16'h2000;
            if (e == 3) d_in = 8'h22;
            if (e == 4) vld_a = 1'b0;
        end
        checks++; if (mask !== 10'b0010001000) begin errors++; $display("FAIL b2b_rsp_edges: got %b expected 0010001000", mask); end
        checks++; if (a2 !== 16'h1000 || a4 !== 16'h2000) begin errors++; $display("FAIL b2b_addr: got %h %h expected 1000 2000", a2, a4); end
        checks++; if (rdy3 !== 1'b1 || rdy4 !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b %b expected 1 0", rdy3, rdy4); end
        checks++; if (rd1 !== 8'h11 || rd2 !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h %h expected 11 22", rd1, rd2); end
    endtask

    task automatic test_reset_midcycle;
        int n_rsp;
        n_rsp = 0;
        @(negedge clk);
        addr = 16'h9000; wdata = 8'h5E; c_write = 1'b1; c_io = 1'b0; c_m1 = 1'b0; wait_n = 1'b0; vld_a = 1'b1;
        @(posedge clk); #1 vld_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wr_a !== 1'b0 || doe_a !== 1'b1) begin errors++; $display("FAIL rst_pre_tw: got wr %b doe %b expected 0 1", wr_a, doe_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mrq_a, iorq_a, rd_a, wr_a, m1_a} !== 5'b11111) begin errors++; $display("FAIL rst_mid_strobes: got %b expected 11111", {mrq_a, iorq_a, rd_a, wr_a, m1_a}); end
        checks++; if (doe_a !== 1'b0 || rdy_a !== 1'b1 || aout_a !== 16'h0) begin errors++; $display("FAIL rst_mid_ctrl: got doe %b ready %b addr %h expected 0 1 0000", doe_a, rdy_a, aout_a); end
        @(negedge clk);
        rst_n = 1'b1; wait_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (rspv_a) n_rsp++;
        end
        checks++; if (n_rsp !== 0 || rdy_a !== 1'b1) begin errors++; $display("FAIL rst_no_rsp: got rsp %0d ready %b expected 0 1", n_rsp, rdy_a); end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_mem_write();
        test_io_read();
        test_wait_timeout();
        test_tclks3();
        test_back_to_back();
        test_reset_midcycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc2014_bus_master.md
# rc2014_bus_master

Z80-style bus initiator: takes single read/write commands from on-FPGA logic and runs the matching RC2014 memory or I/O cycle, so the FPGA can drive the backplane instead of only answering it. Produces registered active-low strobes, address and write data, honours WAIT, and returns read data or a timeout error. Sits between an internal command source (test sequencer, DMA engine) and the bus pads/direction buffers.

## Interface
- T_CLKS, default 1: CLK cycles per T-state (1..15).
- WAIT_MAX, default 255: maximum consecutive wait states (TW) before abort (1..255).
- CLK  in  1  system clock; the bus is synchronous to it.
- RST  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle; command accepted when cmd_valid && cmd_ready at a rising CLK edge.
- cmd_addr  in  16  bus address.
- cmd_wdata  in  8  write data.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_io  in  1  1 = I/O cycle (IORQ), 0 = memory (MRQ).
- cmd_m1  in  1  assert M1 on a memory read (fetch marker); ignored otherwise.
- rsp_valid  out  1  one-CLK pulse: cycle complete.
- rsp_rdata  out  8  read data, valid with rsp_valid (reads only; holds last value otherwise).
- rsp_err  out  1  valid with rsp_valid: WAIT timeout abort.
- A_OUT  out  16  address bus.
- D_OUT  out  8  write data.
- D_IN  in  8  data bus input.
- D_OE  out  1  1 = drive D_OUT onto the bus.
- MRQ, IORQ, RD, WR, M1  out  1 each  active-low bus strobes.
- WAIT  in  1  active-low wait request, synchronous to CLK.

## Operation
- Reset (async, any state): state IDLE; MRQ, IORQ, RD, WR, M1 = 1; D_OE = 0; A_OUT = 0; D_OUT = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; cmd_ready = 1. Outputs take these values immediately on RST low, even mid-cycle; the in-flight command is dropped with no response.
- States: IDLE, T1, T2, TW, T3, TH. Each of T1, T2, TW, T3, TH lasts T_CLKS CLKs (4-bit tick counter, reloaded on every state change).
- IDLE: cmd_ready = 1; on accept latch all cmd_* fields, load A_OUT; for writes load D_OUT and set D_OE = 1; go T1.
- T1: address (and write data) setup; strobes high. Go T2.
- T2: assert MRQ or IORQ per cmd_io, plus RD (read) or WR (write). On the last tick: I/O cycles always go TW (one automatic wait); memory goes TW if WAIT = 0, else T3.
- TW: strobes held. On the last tick: WAIT = 0 and wait count < WAIT_MAX, stay in TW (count+1); WAIT = 0 and count = WAIT_MAX, set abort flag, go T3; WAIT = 1, go T3. The automatic I/O wait counts toward WAIT_MAX.
- T3: strobes held. On the last tick: reads capture D_IN into rsp_rdata (not updated on abort); all strobes go high; rsp_valid = 1, rsp_err = abort flag; reads go IDLE, writes go TH.
- TH (writes only): D_OE stays 1 for data hold; at exit D_OE = 0, go IDLE.
- M1 is low together with MRQ/RD, only for memory reads with cmd_m1 = 1.
- A_OUT holds the last address in IDLE; D_OUT holds the last write data.
- cmd_ready = 0 from the accept edge until the block returns to IDLE. Inputs are ignored while busy.

## Timing
- All outputs are registered and change only on rising CLK (or on async reset).
- With T_CLKS = 1 and the accept edge as edge 0: memory read/write with no wait has strobes low after edges 1..3 and rsp_valid high for the cycle after edge 3. Each TW adds T_CLKS. An I/O cycle with no external wait has rsp_valid after edge 4.
- Write D_OE: high after edge 0, low after the TH exit edge (edge 4 for a zero-wait memory write). cmd_ready returns after edge 3 (read) or edge 4 (write).
- A new command can be accepted in the same cycle rsp_valid is high (read) or after TH (write). This gives back-to-back cycles with no idle gap for reads.
- WAIT is sampled only on the last tick of T2/TW; WAIT pulses at other times are ignored.

## Test plan
- Memory read 0x1234, T_CLKS = 1, WAIT = 1, D_IN = 0xA5 -> MRQ/RD low for exactly 2 CLKs; rsp_valid one CLK 3 cycles after accept; rsp_rdata = 0xA5; rsp_err = 0; IORQ/WR/M1 stay high.
- Memory write 0x8000 = 0x3C -> D_OE high for 4 CLKs covering the WR-low window plus 1 CLK hold; D_OUT = 0x3C; cmd_ready low 4 CLKs.
- I/O read port 0x00FE with WAIT held low for 3 extra samples -> IORQ/RD low for 2 + 1 + 3 = 6 CLKs; rsp_rdata = D_IN at T3; MRQ never low.
- WAIT stuck low, WAIT_MAX = 4 -> exactly 4 TW states then T3; rsp_valid with rsp_err = 1; rsp_rdata unchanged.
- T_CLKS = 3, memory read with cmd_m1 = 1 -> M1/MRQ/RD low for 6 CLKs; rsp_valid 9 CLKs after accept.
- RST low during TW of a write -> all strobes high, D_OE = 0 and cmd_ready = 1 without a clock edge; no rsp_valid after release.
